// File: rtl/hilo_ctrl.sv
// HI/LO register unit and divide sequencer: MULT/MULTU/MTHI/MTLO complete in one edge,
// DIV/DIVU are handed to the external multi-cycle divider. Optional feature macro: HILO_DIV0_EN.
module hilo_ctrl (
    input  logic        clk,
    input  logic        hilorst,
    input  logic [2:0]  op,
    input  logic        opvalid,
    input  logic [31:0] rsval,
    input  logic [31:0] rtval,
    input  logic        mfreq,
    output logic [31:0] diva,
    output logic [31:0] divb,
    output logic        signdiv,
    output logic        divrst,
    input  logic [31:0] divq,
    input  logic [31:0] divr,
    input  logic        divdone,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
`ifdef HILO_DIV0_EN
    output logic        hilostall,
    output logic        div0
`else
    output logic        hilostall
`endif
);

    localparam int unsigned W  = 32;
    localparam int unsigned W2 = 2 * W;

    localparam logic [2:0] OP_NOP0  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_NOP7  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WLOW  = 3'd2,
        S_WHIGH = 3'd3,
        S_WB    = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   diva_q, diva_d;
    logic [W-1:0]   divb_q, divb_d;
    logic           signdiv_q, signdiv_d;
    logic           divrst_q, divrst_d;
    logic           busy_q, busy_d;
`ifdef HILO_DIV0_EN
    logic           div0_q, div0_d;
`endif

    logic           accept_c;
    logic           div_skip_c;
    logic [W2-1:0]  rs_sx_c, rt_sx_c;
    logic [W2-1:0]  prod_s_c, prod_u_c;

    assign accept_c = opvalid & ~busy_q;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign rs_sx_c  = {{W{rsval[W-1]}}, rsval};
    assign rt_sx_c  = {{W{rtval[W-1]}}, rtval};
    assign prod_s_c = rs_sx_c * rt_sx_c;
    assign prod_u_c = {W'(0), rsval} * {W'(0), rtval};

`ifdef HILO_DIV0_EN
    assign div_skip_c = (rtval == W'(0));
`else
    assign div_skip_c = 1'b0;
`endif

    // Next-state, HI/LO and divider-interface logic
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        diva_d    = diva_q;
        divb_d    = divb_q;
        signdiv_d = signdiv_q;
        divrst_d  = 1'b0;
`ifdef HILO_DIV0_EN
        div0_d    = div0_q;
`endif

        case (state_q)
            S_IDLE: begin
                // divdone is deliberately not looked at here: a completion left over
                // from an aborted division must never reach HI/LO.
                if (accept_c) begin
                    case (op)
                        OP_DIV, OP_DIVU: begin
                            if (!div_skip_c) begin
                                diva_d    = rsval;
                                divb_d    = rtval;
                                signdiv_d = (op == OP_DIV);
                                divrst_d  = 1'b1;
                                state_d   = S_START;
                            end
`ifdef HILO_DIV0_EN
                            div0_d = div_skip_c;
`endif
                        end
                        OP_MULT:  {hi_d, lo_d} = prod_s_c;
                        OP_MULTU: {hi_d, lo_d} = prod_u_c;
                        OP_MTHI:  hi_d = rsval;
                        OP_MTLO:  lo_d = rsval;
                        default:  ;
                    endcase
                end
            end
            S_START: begin
                state_d = S_WLOW;
            end
            S_WLOW: begin
                if (!divdone) begin
                    state_d = S_WHIGH;
                end
            end
            S_WHIGH: begin
                if (divdone) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                lo_d    = divq;
                hi_d    = divr;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge hilorst) begin
        if (hilorst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            diva_q    <= '0;
            divb_q    <= '0;
            signdiv_q <= 1'b0;
            divrst_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef HILO_DIV0_EN
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            diva_q    <= diva_d;
            divb_q    <= divb_d;
            signdiv_q <= signdiv_d;
            divrst_q  <= divrst_d;
            busy_q    <= busy_d;
`ifdef HILO_DIV0_EN
            div0_q    <= div0_d;
`endif
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign diva    = diva_q;
    assign divb    = divb_q;
    assign signdiv = signdiv_q;
    assign divrst  = divrst_q;
    assign busy    = busy_q;
`ifdef HILO_DIV0_EN
    assign div0    = div0_q;
`endif

    // Stall decode for any real HI/LO op or MF read while a division is in flight.
    assign hilostall = busy_q & (mfreq | (opvalid & (op != OP_NOP0) & (op != OP_NOP7)));

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: behavioural divider model, directed cases, then random ops
// checked against an arithmetic HI/LO reference model.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        hilorst;
    logic [2:0]  op;
    logic        opvalid;
    logic [31:0] rsval, rtval;
    logic        mfreq;
    logic [31:0] diva, divb;
    logic        signdiv, divrst;
    logic [31:0] divq, divr;
    logic        divdone = 1'b1;
    logic [31:0] hi, lo;
    logic        busy, hilostall;
`ifdef HILO_DIV0_EN
    logic        div0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_hi, exp_lo;
    logic        exp_div0;
    int unsigned dcnt = 0;
    int unsigned lat_force = 0;

    hilo_ctrl dut (
        .clk       (clk),
        .hilorst   (hilorst),
        .op        (op),
        .opvalid   (opvalid),
        .rsval     (rsval),
        .rtval     (rtval),
        .mfreq     (mfreq),
        .diva      (diva),
        .divb      (divb),
        .signdiv   (signdiv),
        .divrst    (divrst),
        .divq      (divq),
        .divr      (divr),
        .divdone   (divdone),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
`ifdef HILO_DIV0_EN
        .hilostall (hilostall),
        .div0      (div0)
`else
        .hilostall (hilostall)
`endif
    );

    always #5 clk = ~clk;

    // Truncating division; divide by zero returns q=all-ones, r=dividend. Result is {r, q}.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Divider model: start pulse drops divdone, random latency, then divdone rises.
    always @(posedge clk) begin
        if (divrst) begin
            divdone <= 1'b0;
            dcnt    <= (lat_force != 0) ? lat_force : $urandom_range(26, 1);
        end else if (!divdone) begin
            if (dcnt == 0) divdone <= 1'b1;
            else           dcnt    <= dcnt - 1;
        end
    end

    assign {divr, divq} = div_ref(diva, divb, signdiv);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, update the reference model, follow a division to completion, check results.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic   is_div, run, held_ok;
        int     cyc, pulses;
        longint p;
        is_div = (o == 3'd1) || (o == 3'd2);
        run    = is_div;
`ifdef HILO_DIV0_EN
        if (is_div && b == 32'd0) run = 1'b0;
`endif
        @(negedge clk);
        op = o; rsval = a; rtval = b; opvalid = 1'b1;
        @(negedge clk);
        opvalid = 1'b0; op = 3'd0;

        case (o)
            3'd1, 3'd2: begin
`ifdef HILO_DIV0_EN
                exp_div0 = (b == 32'd0);
`endif
                if (run) {exp_hi, exp_lo} = div_ref(a, b, o == 3'd1);
            end
            3'd3: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {exp_hi, exp_lo} = p;
            end
            3'd4: {exp_hi, exp_lo} = {32'd0, a} * {32'd0, b};
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase

        if (run) begin
            check("busy_after_div", 64'(busy), 64'd1);
            check("divrst_start", 64'(divrst), 64'd1);
            check("div_operands", {diva, divb}, {a, b});
            check("signdiv", 64'(signdiv), 64'(o == 3'd1));
            mfreq = 1'b1;
            #1;
            check("stall_mfreq_busy", 64'(hilostall), 64'd1);
            mfreq = 1'b0;
            pulses = 0; held_ok = 1'b1; cyc = 0;
            while (busy && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (divrst) pulses++;
                if ({diva, divb} !== {a, b} || signdiv !== (o == 3'd1)) held_ok = 1'b0;
            end
            check("div_timeout_busy", 64'(busy), 64'd0);
            check("divrst_width", 64'(pulses), 64'd0);
            check("div_operand_hold", 64'(held_ok), 64'd1);
        end else begin
            check("busy_nondiv", 64'(busy), 64'd0);
        end
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
`ifdef HILO_DIV0_EN
        check("div0", 64'(div0), 64'(exp_div0));
`endif
    endtask

    initial begin
        int cyc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        hilorst = 1'b1; opvalid = 1'b0; op = 3'd0; rsval = '0; rtval = '0; mfreq = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_divrst", 64'(divrst), 64'd0);
        check("rst_operands", {diva, divb}, 64'd0);
        check("rst_signdiv", 64'(signdiv), 64'd0);
        hilorst = 1'b0;

        do_op(3'd1, 32'd100, 32'd7);
        check("div_100_7", {hi, lo}, {32'd2, 32'd14});
        do_op(3'd1, 32'hFFFFFF9C, 32'd7);
        check("div_m100_7", {hi, lo}, {32'hFFFFFFFE, 32'hFFFFFFF2});
        do_op(3'd2, 32'hFFFFFFFF, 32'd2);
        check("divu_max_2", {hi, lo}, {32'd1, 32'h7FFFFFFF});
        do_op(3'd3, 32'hFFFFFFFD, 32'd5);
        check("mult_m3_5", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        do_op(3'd4, 32'hFFFFFFFF, 32'd2);
        check("multu_max_2", {hi, lo}, {32'd1, 32'hFFFFFFFE});
        do_op(3'd1, 32'h80000000, 32'hFFFFFFFF);
        check("div_overflow", {hi, lo}, {32'd0, 32'h80000000});

        @(negedge clk);
        mfreq = 1'b1; #1;
        check("stall_idle_mfreq", 64'(hilostall), 64'd0);
        mfreq = 1'b0;

        // MTLO presented while a division runs: held by stall, taken after writeback.
        @(negedge clk);
        op = 3'd1; rsval = 32'd100; rtval = 32'd7; opvalid = 1'b1;
        @(negedge clk);
        op = 3'd6; rsval = 32'h1234; rtval = 32'd0; mfreq = 1'b1;
        #1;
        check("mtlo_busy_stall", 64'(hilostall), 64'd1);
        cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mtlo_wait_busy", 64'(busy), 64'd0);
        check("mtlo_not_yet", {hi, lo}, {32'd2, 32'd14});
        check("mtlo_stall_drop", 64'(hilostall), 64'd0);
        @(negedge clk);
        opvalid = 1'b0; op = 3'd0; mfreq = 1'b0;
        check("mtlo_after_wb", {hi, lo}, {32'd2, 32'h1234});
        exp_hi = 32'd2; exp_lo = 32'h1234;

        // Reset while waiting for divdone high; the late completion must not write.
        do_op(3'd5, 32'hCAFE0000, 32'd0);
        lat_force = 20;
        @(negedge clk);
        op = 3'd2; rsval = 32'd50; rtval = 32'd5; opvalid = 1'b1;
        @(negedge clk);
        opvalid = 1'b0; op = 3'd0;
        cyc = 0;
        while (divdone && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_low_seen", 64'(divdone), 64'd0);
        @(negedge clk);
        hilorst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_divrst", 64'(divrst), 64'd0);
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        @(negedge clk);
        hilorst = 1'b0;
        cyc = 0;
        while (!divdone && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("stale_done_rose", 64'(divdone), 64'd1);
        repeat (3) @(negedge clk);
        check("stale_no_write", {hi, lo}, 64'd0);
        check("stale_no_busy", 64'(busy), 64'd0);
        lat_force = 0;

        do_op(3'd6, 32'h00000055, 32'd0);
        do_op(3'd1, 32'd5, 32'd0);
`ifdef HILO_DIV0_EN
        check("div0_set", 64'(div0), 64'd1);
        check("div0_hilo_kept", {hi, lo}, {32'd0, 32'h55});
`endif
        do_op(3'd1, 32'd9, 32'd3);
        check("div_9_3", {hi, lo}, {32'd0, 32'd3});

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom();
            endcase
            do_op(ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule
